// File: rtl/mat_pkg.sv
// Shared definitions for the matrix memory arbiter: FSM states, owner codes,
// memory select codes and the select-to-enable decode.
package mat_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN_H = 2'd1,
      ST_OWN_C = 2'd2
   } state_t;

   localparam logic OWN_HOST = 1'b0;
   localparam logic OWN_CTRL = 1'b1;

   localparam logic [1:0] SEL_M1   = 2'd0;
   localparam logic [1:0] SEL_M2   = 2'd1;
   localparam logic [1:0] SEL_M3   = 2'd2;
   localparam logic [1:0] SEL_NONE = 2'd3;

   // one-hot {M3,M2,M1}; the invalid select enables nothing
   function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
      logic [2:0] oh;
      case (sel)
         SEL_M1:  oh = 3'b001;
         SEL_M2:  oh = 3'b010;
         SEL_M3:  oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin tie-break: a lone requester wins; on a tie the side
// that did not own the memories last wins.
module rr_pick2
   import mat_pkg::*;
(
   input  logic i_req_h,
   input  logic i_req_c,
   input  logic i_last_owner,
   output logic o_valid,
   output logic o_winner
);

   // pick the winner from the two requests and the previous owner
   always_comb begin
      o_valid  = i_req_h | i_req_c;
      o_winner = OWN_HOST;
      if (i_req_h && i_req_c)
         o_winner = (i_last_owner == OWN_HOST) ? OWN_CTRL : OWN_HOST;
      else if (i_req_c)
         o_winner = OWN_CTRL;
   end

endmodule

// File: rtl/mat_mem_arbiter.sv
// Arbitrates the three matrix memories between the host port and the
// multiply controller with burst ownership, a fairness limit and tagged
// read return.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | nobody owns the memories, waiting for a request
//   ST_OWN_H | host owns the memories, its accesses pass through
//   ST_OWN_C | controller owns the memories
module mat_mem_arbiter
   import mat_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int MAX_BURST = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_h_req,
   input  logic [1:0]            i_h_sel,
   input  logic [ADDR_W-1:0]     i_h_addr,
   input  logic                  i_h_wr,
   input  logic [DATA_W-1:0]     i_h_wdata,
   output logic                  o_h_gnt,
   output logic                  o_h_rvalid,
   output logic [DATA_W-1:0]     o_h_rdata,
   input  logic                  i_c_req,
   input  logic [1:0]            i_c_sel,
   input  logic [ADDR_W-1:0]     i_c_addr,
   input  logic                  i_c_wr,
   input  logic [DATA_W-1:0]     i_c_wdata,
   output logic                  o_c_gnt,
   output logic                  o_c_rvalid,
   output logic [DATA_W-1:0]     o_c_rdata,
   output logic [2:0]            o_m_en,
   output logic                  o_m_wen,
   output logic [ADDR_W-1:0]     o_m_addr,
   output logic [DATA_W-1:0]     o_m_wdata,
   input  logic [3*DATA_W-1:0]   i_m_rdata,
   output logic                  o_err
);

   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_last_owner;
   logic [CNT_W-1:0]    r_burst_cnt;
   logic                r_tag_vld;
   logic                r_tag_own;
   logic [1:0]          r_tag_sel;
   logic                r_err;
   logic [DATA_W-1:0]   r_h_rdata;
   logic [DATA_W-1:0]   r_c_rdata;

   logic                w_h_gnt;
   logic                w_c_gnt;
   logic                w_pick_vld;
   logic                w_pick_own;
   logic                w_acc;
   logic                w_burst_end;
   logic [1:0]          w_sel;
   logic [ADDR_W-1:0]   w_addr;
   logic                w_wr;
   logic [DATA_W-1:0]   w_wdata;
   logic [DATA_W-1:0]   w_ret_data;

   rr_pick2 u_pick (
      .i_req_h      (i_h_req),
      .i_req_c      (i_c_req),
      .i_last_owner (r_last_owner),
      .o_valid      (w_pick_vld),
      .o_winner     (w_pick_own)
   );

   // state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // next state: grant from idle, release on dropped req, forced hand-over at burst end
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_vld)
               w_state_nxt = (w_pick_own == OWN_HOST) ? ST_OWN_H : ST_OWN_C;
         end
         ST_OWN_H: begin
            if (!i_h_req)                 w_state_nxt = i_c_req ? ST_OWN_C : ST_IDLE;
            else if (w_burst_end && i_c_req) w_state_nxt = ST_OWN_C;
         end
         ST_OWN_C: begin
            if (!i_c_req)                 w_state_nxt = i_h_req ? ST_OWN_H : ST_IDLE;
            else if (w_burst_end && i_h_req) w_state_nxt = ST_OWN_H;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // grants decode from the registered state
   always_comb begin
      w_h_gnt = (r_state == ST_OWN_H);
      w_c_gnt = (r_state == ST_OWN_C);
   end

   assign o_h_gnt = w_h_gnt;
   assign o_c_gnt = w_c_gnt;

   // owner pass-through; the non-owner never reaches the memories
   always_comb begin
      w_sel       = w_c_gnt ? i_c_sel   : i_h_sel;
      w_addr      = w_c_gnt ? i_c_addr  : i_h_addr;
      w_wr        = w_c_gnt ? i_c_wr    : i_h_wr;
      w_wdata     = w_c_gnt ? i_c_wdata : i_h_wdata;
      w_acc       = (w_h_gnt & i_h_req) | (w_c_gnt & i_c_req);
      w_burst_end = w_acc & (r_burst_cnt == CNT_LAST);
      o_m_en      = w_acc ? sel_onehot(w_sel) : 3'b000;
      o_m_wen     = w_acc & w_wr & (w_sel != SEL_NONE);
      o_m_addr    = w_acc ? w_addr  : '0;
      o_m_wdata   = w_acc ? w_wdata : '0;
   end

   // ownership history and burst length; the counter saturates when nobody waits
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last_owner <= OWN_CTRL;
         r_burst_cnt  <= '0;
      end else if (w_state_nxt != r_state) begin
         r_burst_cnt <= '0;
         if (w_state_nxt == ST_OWN_H) r_last_owner <= OWN_HOST;
         if (w_state_nxt == ST_OWN_C) r_last_owner <= OWN_CTRL;
      end else if (w_acc && (r_burst_cnt != CNT_LAST)) begin
         r_burst_cnt <= r_burst_cnt + 1'b1;
      end
   end

   // read tag and error pulse; the tag outlives a hand-over
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tag_vld <= 1'b0;
         r_tag_own <= OWN_HOST;
         r_tag_sel <= SEL_M1;
         r_err     <= 1'b0;
      end else begin
         r_tag_vld <= w_acc & ~w_wr;
         r_err     <= w_acc & (w_sel == SEL_NONE);
         if (w_acc && !w_wr) begin
            r_tag_own <= w_c_gnt ? OWN_CTRL : OWN_HOST;
            r_tag_sel <= w_sel;
         end
      end
   end

   // select the returning memory slice
   always_comb begin
      case (r_tag_sel)
         SEL_M1:  w_ret_data = i_m_rdata[DATA_W-1:0];
         SEL_M2:  w_ret_data = i_m_rdata[2*DATA_W-1:DATA_W];
         SEL_M3:  w_ret_data = i_m_rdata[3*DATA_W-1:2*DATA_W];
         default: w_ret_data = '0;
      endcase
   end

   // return demux to the tagged requester; read data holds between valids
   always_comb begin
      o_h_rvalid = r_tag_vld & (r_tag_own == OWN_HOST);
      o_c_rvalid = r_tag_vld & (r_tag_own == OWN_CTRL);
      o_h_rdata  = o_h_rvalid ? w_ret_data : r_h_rdata;
      o_c_rdata  = o_c_rvalid ? w_ret_data : r_c_rdata;
      o_err      = r_err;
   end

   // capture returned data so it stays on the bus afterwards
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_h_rdata <= '0;
         r_c_rdata <= '0;
      end else begin
         if (o_h_rvalid) r_h_rdata <= w_ret_data;
         if (o_c_rvalid) r_c_rdata <= w_ret_data;
      end
   end

endmodule

// File: tb/tb_mat_mem_arbiter.sv
// Bench for the matrix memory arbiter: a behavioural memory plus an
// ownership/read-return model, directed scenarios and a random run.
module tb_mat_mem_arbiter;

   localparam int MAXB = 16;

   logic       clk, rst_n;
   logic       h_req, h_wr, c_req, c_wr;
   logic [1:0] h_sel, c_sel;
   logic [7:0] h_addr, h_wdata, c_addr, c_wdata;
   logic       h_gnt, h_rvalid, c_gnt, c_rvalid, m_wen, err;
   logic [7:0] h_rdata, c_rdata, m_addr, m_wdata;
   logic [2:0] m_en;
   logic [23:0] m_rdata;

   int n_checks;
   int n_fail;

   mat_mem_arbiter #(.DATA_W(8), .ADDR_W(8), .MAX_BURST(MAXB)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_h_req(h_req), .i_h_sel(h_sel), .i_h_addr(h_addr), .i_h_wr(h_wr), .i_h_wdata(h_wdata),
      .o_h_gnt(h_gnt), .o_h_rvalid(h_rvalid), .o_h_rdata(h_rdata),
      .i_c_req(c_req), .i_c_sel(c_sel), .i_c_addr(c_addr), .i_c_wr(c_wr), .i_c_wdata(c_wdata),
      .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
      .o_m_en(m_en), .o_m_wen(m_wen), .o_m_addr(m_addr), .o_m_wdata(m_wdata),
      .i_m_rdata(m_rdata), .o_err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // memory macros: synchronous write, read data registered one cycle later
   logic [7:0] mem [0:2][0:255];
   logic [7:0] rd_q [0:2];
   assign m_rdata = {rd_q[2], rd_q[1], rd_q[0]};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) begin
            rd_q[k] <= 8'h00;
            for (int a = 0; a < 256; a++) mem[k][a] <= 8'($urandom);
         end
      end else begin
         for (int k = 0; k < 3; k++)
            if (m_en[k]) begin
               if (m_wen) mem[k][m_addr] <= m_wdata;
               else       rd_q[k] <= mem[k][m_addr];
            end
      end
   end

   // reference model: owner 0=none 1=host 2=ctrl
   int         mo_own, mo_last, mo_cnt, mo_rv_who;
   bit         mo_rv, mo_err;
   logic [7:0] mo_rv_data, mo_h_hold, mo_c_hold;
   int         t_nxt, t_oth;
   bit         t_mine, t_other;

   bit         e_hg, e_cg, e_acc, e_wr, e_hrv, e_crv;
   logic [1:0] e_sel;
   logic [7:0] e_addr, e_wdata, e_hrd, e_crd;
   logic [2:0] e_men;
   logic [40:0] exp_vec, dut_vec;

   always_comb begin
      e_hg    = (mo_own == 1);
      e_cg    = (mo_own == 2);
      e_acc   = (e_hg && h_req) || (e_cg && c_req);
      e_sel   = e_cg ? c_sel   : h_sel;
      e_addr  = e_cg ? c_addr  : h_addr;
      e_wr    = e_cg ? c_wr    : h_wr;
      e_wdata = e_cg ? c_wdata : h_wdata;
      e_men   = (e_acc && e_sel != 2'd3) ? (3'b001 << e_sel) : 3'b000;
      e_hrv   = mo_rv && (mo_rv_who == 1);
      e_crv   = mo_rv && (mo_rv_who == 2);
      e_hrd   = e_hrv ? mo_rv_data : mo_h_hold;
      e_crd   = e_crv ? mo_rv_data : mo_c_hold;
      exp_vec = {e_hg, e_hrv, e_hrd, e_cg, e_crv, e_crd, e_men,
                 (e_acc && e_wr && e_sel != 2'd3),
                 (e_acc ? e_addr : 8'h00), (e_acc ? e_wdata : 8'h00), mo_err};
      dut_vec = {h_gnt, h_rvalid, h_rdata, c_gnt, c_rvalid, c_rdata, m_en,
                 m_wen, m_addr, m_wdata, err};
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mo_own <= 0; mo_last <= 2; mo_cnt <= 0;
         mo_rv <= 1'b0; mo_rv_who <= 0; mo_rv_data <= 8'h00;
         mo_h_hold <= 8'h00; mo_c_hold <= 8'h00; mo_err <= 1'b0;
      end else begin
         mo_rv  <= e_acc && !e_wr;
         mo_err <= e_acc && (e_sel == 2'd3);
         if (e_acc && !e_wr) begin
            mo_rv_who  <= mo_own;
            mo_rv_data <= (e_sel == 2'd3) ? 8'h00 : mem[int'(e_sel)][e_addr];
         end
         if (e_hrv) mo_h_hold <= mo_rv_data;
         if (e_crv) mo_c_hold <= mo_rv_data;
         if (mo_own == 0) begin
            if (h_req && c_req) t_nxt = (mo_last == 1) ? 2 : 1;
            else if (h_req)     t_nxt = 1;
            else if (c_req)     t_nxt = 2;
            else                t_nxt = 0;
         end else begin
            t_mine  = (mo_own == 1) ? h_req : c_req;
            t_other = (mo_own == 1) ? c_req : h_req;
            t_oth   = 3 - mo_own;
            if (!t_mine)                                  t_nxt = t_other ? t_oth : 0;
            else if (e_acc && mo_cnt == MAXB-1 && t_other) t_nxt = t_oth;
            else                                          t_nxt = mo_own;
         end
         if (t_nxt != mo_own) begin
            mo_cnt <= 0;
            if (t_nxt != 0) mo_last <= t_nxt;
         end else if (e_acc && mo_cnt < MAXB-1) begin
            mo_cnt <= mo_cnt + 1;
         end
         mo_own <= t_nxt;
      end
   end

   task automatic drive(input bit hr, input logic [1:0] hs, input logic [7:0] ha, input bit hw,
                        input logic [7:0] hd, input bit cr, input logic [1:0] cs,
                        input logic [7:0] ca, input bit cw, input logic [7:0] cd);
      h_req = hr; h_sel = hs; h_addr = ha; h_wr = hw; h_wdata = hd;
      c_req = cr; c_sel = cs; c_addr = ca; c_wr = cw; c_wdata = cd;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #80;
      n_checks++;
      if (dut_vec !== 41'd0) begin
         n_fail++; $display("FAIL reset_outputs got=%h want=0", dut_vec);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_checks++;
         if (dut_vec !== 41'd0 || dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL reset_idle got=%h want=%h", dut_vec, exp_vec);
         end
      end
   endtask

   task automatic test_single_read();
      logic [7:0] want;
      do_reset();
      @(negedge clk); drive(0, 0, 0, 0, 0, 1, 2'd0, 8'h05, 0, 8'h00); #1;
      n_checks++;
      if (c_gnt !== 1'b0 || dut_vec !== exp_vec) begin
         n_fail++; $display("FAIL read_req_cycle got=%h want=%h", dut_vec, exp_vec);
      end
      @(negedge clk); #1;
      n_checks++;
      if (c_gnt !== 1'b1 || m_en !== 3'b001 || m_addr !== 8'h05 || m_wen !== 1'b0) begin
         n_fail++; $display("FAIL read_access gnt=%b en=%b addr=%h want 1/001/05", c_gnt, m_en, m_addr);
      end
      want = mem[0][5];
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
      n_checks++;
      if (c_rvalid !== 1'b1 || c_rdata !== want || h_rvalid !== 1'b0) begin
         n_fail++; $display("FAIL read_return rv=%b data=%h hrv=%b want 1/%h/0", c_rvalid, c_rdata, h_rvalid, want);
      end
      n_checks++;
      if (dut_vec !== exp_vec) begin
         n_fail++; $display("FAIL read_return_model got=%h want=%h", dut_vec, exp_vec);
      end
   endtask

   task automatic test_tie();
      do_reset();
      @(negedge clk); drive(1, 2'd1, 8'h33, 1, 8'hA5, 1, 2'd2, 8'h10, 0, 8'h00); #1;
      n_checks++;
      if (h_gnt !== 1'b0 || c_gnt !== 1'b0) begin
         n_fail++; $display("FAIL tie_no_early_gnt h=%b c=%b want 0/0", h_gnt, c_gnt);
      end
      @(negedge clk); #1;
      n_checks++;
      if (h_gnt !== 1'b1 || c_gnt !== 1'b0 || dut_vec !== exp_vec) begin
         n_fail++; $display("FAIL tie_host_first h=%b c=%b vec=%h want=%h", h_gnt, c_gnt, dut_vec, exp_vec);
      end
      @(negedge clk); h_req = 1'b0; #1;
      n_checks++;
      if (dut_vec !== exp_vec) begin
         n_fail++; $display("FAIL tie_release got=%h want=%h", dut_vec, exp_vec);
      end
      @(negedge clk); #1;
      n_checks++;
      if (c_gnt !== 1'b1 || h_gnt !== 1'b0 || dut_vec !== exp_vec) begin
         n_fail++; $display("FAIL tie_direct_handover c=%b h=%b want 1/0", c_gnt, h_gnt);
      end
      @(negedge clk); c_req = 1'b0; #1;
      n_checks++;
      if (dut_vec !== exp_vec) begin
         n_fail++; $display("FAIL tie_ctrl_done got=%h want=%h", dut_vec, exp_vec);
      end
   endtask

   task automatic test_burst_limit();
      int h_done = 0, c_done = 0, wen_first = 0, wen_host = 0, cyc = 0;
      bit handed = 0;
      do_reset();
      while ((h_done < 20 || c_done < 3) && cyc < 200) begin
         @(negedge clk);
         drive(h_done < 20, 2'd0, 8'(h_done), 1, 8'($urandom),
               c_done < 3, 2'd2, 8'(c_done), 1, 8'($urandom));
         #1;
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL burst_cycle%0d got=%h want=%h", cyc, dut_vec, exp_vec);
         end
         if (e_cg) handed = 1;
         if (e_hg && m_wen) begin
            wen_host++;
            if (!handed) wen_first++;
         end
         if (e_hg && h_req) h_done++;
         if (e_cg && c_req) c_done++;
         cyc++;
      end
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (cyc >= 200) begin
         n_fail++; $display("FAIL burst_timeout h_done=%0d c_done=%0d", h_done, c_done);
      end
      n_checks++;
      if (wen_first !== MAXB) begin
         n_fail++; $display("FAIL burst_first_wen got=%0d want=%0d", wen_first, MAXB);
      end
      n_checks++;
      if (wen_host !== 20) begin
         n_fail++; $display("FAIL burst_total_wen got=%0d want=20", wen_host);
      end
   endtask

   task automatic test_handover_read();
      bit prev_cg = 0, seen = 0;
      int cyc = 0;
      do_reset();
      @(negedge clk); drive(0, 0, 0, 0, 0, 1, 2'd1, 8'h00, 0, 0);
      while (!seen && cyc < 60) begin
         @(negedge clk);
         drive(1, 2'd0, 8'h44, 0, 0, 1, 2'($urandom_range(0, 2)), 8'($urandom), 0, 0);
         #1;
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL handover_cycle%0d got=%h want=%h", cyc, dut_vec, exp_vec);
         end
         if (prev_cg && e_hg) begin
            seen = 1;
            n_checks++;
            if (c_rvalid !== 1'b1 || h_gnt !== 1'b1 || h_rvalid !== 1'b0) begin
               n_fail++; $display("FAIL handover_last_read crv=%b hg=%b hrv=%b want 1/1/0", c_rvalid, h_gnt, h_rvalid);
            end
         end
         prev_cg = e_cg;
         cyc++;
      end
      n_checks++;
      if (!seen) begin
         n_fail++; $display("FAIL handover_timeout cycles=%0d", cyc);
      end
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_bad_sel();
      do_reset();
      @(negedge clk); drive(1, 2'd3, 8'h21, 1, 8'h77, 0, 0, 0, 0, 0);
      @(negedge clk); #1;
      n_checks++;
      if (h_gnt !== 1'b1 || m_en !== 3'b000 || m_wen !== 1'b0 || err !== 1'b0) begin
         n_fail++; $display("FAIL badsel_write gnt=%b en=%b wen=%b err=%b want 1/000/0/0", h_gnt, m_en, m_wen, err);
      end
      @(negedge clk); h_wr = 1'b0; #1;
      n_checks++;
      if (err !== 1'b1 || m_en !== 3'b000) begin
         n_fail++; $display("FAIL badsel_err_pulse err=%b en=%b want 1/000", err, m_en);
      end
      @(negedge clk); h_req = 1'b0; #1;
      n_checks++;
      if (h_rvalid !== 1'b1 || h_rdata !== 8'h00 || err !== 1'b1) begin
         n_fail++; $display("FAIL badsel_read rv=%b data=%h err=%b want 1/00/1", h_rvalid, h_rdata, err);
      end
      @(negedge clk); #1;
      n_checks++;
      if (err !== 1'b0 || h_rvalid !== 1'b0 || dut_vec !== exp_vec) begin
         n_fail++; $display("FAIL badsel_clear err=%b rv=%b want 0/0", err, h_rvalid);
      end
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      @(negedge clk); drive(0, 0, 0, 0, 0, 1, 2'd2, 8'h09, 0, 0);
      @(negedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (c_rvalid !== 1'b0 || c_gnt !== 1'b0 || dut_vec !== 41'd0) begin
         n_fail++; $display("FAIL reset_mid_read got=%h want=0", dut_vec);
      end
      @(negedge clk); rst_n = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); #1;
      n_checks++;
      if (dut_vec !== 41'd0 || dut_vec !== exp_vec) begin
         n_fail++; $display("FAIL reset_mid_idle got=%h want=0", dut_vec);
      end
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         drive($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom_range(0, 7)), 1'($urandom), 8'($urandom),
               $urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom_range(0, 7)), 1'($urandom), 8'($urandom));
         #1;
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_fail++;
            if (bad < 10) $display("FAIL random_cycle%0d got=%h want=%h", i, dut_vec, exp_vec);
            bad++;
         end
      end
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_single_read();
      test_tie();
      test_burst_limit();
      test_handover_read();
      test_bad_sel();
      test_reset_mid_read();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
